// File: rtl/huffman_flow_ctrl_pkg.sv
// Shared state codes and datapath sizes for the Huffman job sequencer.
package huffman_flow_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_COUNT  = 3'd1,
    ST_TREE   = 3'd2,
    ST_CODE   = 3'd3,
    ST_ENCODE = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

  localparam int NSYM    = 19;
  localparam int NODE_W  = 28;
  localparam int TABLE_W = 130;

  // Stages that wait on a downstream done and are guarded by the watchdog.
  function automatic logic is_wait(input state_t s);
    return (s == ST_COUNT) || (s == ST_TREE) || (s == ST_CODE) || (s == ST_ENCODE);
  endfunction

endpackage

// File: rtl/huffman_flow_ctrl_if.sv
// Control/status bundle between the job sequencer and the Huffman stages.
interface huffman_flow_ctrl_if #(
  parameter int CYC_W = 20
);
  logic             start;
  logic             abort;
  logic             clr_err;
  logic             cnt_done;
  logic             tree_done;
  logic             code_over;
  logic             enc_done;
  logic             cnt_start;
  logic             tree_start;
  logic             tree_over;
  logic             table_load;
  logic             enc_start;
  logic             busy;
  logic             done;
  logic             aborted;
  logic             err;
  logic [2:0]       err_stage;
  logic [CYC_W-1:0] job_cycles;

  modport slave (
    input  start, abort, clr_err, cnt_done, tree_done, code_over, enc_done,
    output cnt_start, tree_start, tree_over, table_load, enc_start,
           busy, done, aborted, err, err_stage, job_cycles
  );

  modport master (
    output start, abort, clr_err, cnt_done, tree_done, code_over, enc_done,
    input  cnt_start, tree_start, tree_over, table_load, enc_start,
           busy, done, aborted, err, err_stage, job_cycles
  );
endinterface

// File: rtl/huffman_flow_ctrl_stage_watchdog.sv
// Per-stage cycle watchdog: counts while enabled, pulses expire at TIMEOUT-1.
module huffman_flow_ctrl_stage_watchdog #(
  parameter int TIMEOUT = 1000,
  parameter int TMO_W   = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);
  localparam logic [TMO_W-1:0] LIMIT = TMO_W'(TIMEOUT - 1);

  logic [TMO_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // A clear in the same cycle means the stage is leaving anyway, so no expiry.
  assign o_expire = i_en & ~i_clr & (r_cnt == LIMIT);

endmodule

// File: rtl/huffman_flow_ctrl.sv
// Huffman job sequencer: strobes each stage in turn, watchdogs the waits, times the job.
module huffman_flow_ctrl
  import huffman_flow_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1000,
  parameter int TMO_W   = 16,
  parameter int CYC_W   = 20
) (
  input  logic                i_clk,
  input  logic                i_rst,
  huffman_flow_ctrl_if.slave  bus
);
  localparam logic [CYC_W-1:0] CYC_MAX = '1;

  state_t           r_state;
  logic             r_cnt_start, r_tree_start, r_tree_over, r_table_load, r_enc_start;
  logic             r_busy, r_done, r_aborted, r_err;
  logic [2:0]       r_err_stage;
  logic [CYC_W-1:0] r_job_cycles;

  logic w_wait, w_stage_done, w_wd_clr, w_expire;

  function automatic logic [CYC_W-1:0] sat_inc(input logic [CYC_W-1:0] v);
    return (v == CYC_MAX) ? v : v + 1'b1;
  endfunction

  assign w_wait = is_wait(r_state);

  always_comb begin
    w_stage_done = 1'b0;
    case (r_state)
      ST_COUNT:  w_stage_done = bus.cnt_done;
      ST_TREE:   w_stage_done = bus.tree_done;
      ST_CODE:   w_stage_done = bus.code_over;
      ST_ENCODE: w_stage_done = bus.enc_done;
      default:   w_stage_done = 1'b0;
    endcase
  end

  // Every exit from a wait state goes through abort or done; expiry leaves via ERR (not a wait).
  assign w_wd_clr = ~w_wait | bus.abort | w_stage_done;

  huffman_flow_ctrl_stage_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TMO_W   (TMO_W)
  ) u_wdog (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_clr    (w_wd_clr),
    .i_en     (w_wait),
    .o_expire (w_expire)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= ST_IDLE;
      r_cnt_start  <= 1'b0;
      r_tree_start <= 1'b0;
      r_tree_over  <= 1'b0;
      r_table_load <= 1'b0;
      r_enc_start  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_err        <= 1'b0;
      r_err_stage  <= '0;
      r_job_cycles <= '0;
    end else begin
      r_cnt_start  <= 1'b0;
      r_tree_start <= 1'b0;
      r_table_load <= 1'b0;
      r_enc_start  <= 1'b0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            r_state      <= ST_COUNT;
            r_cnt_start  <= 1'b1;
            r_busy       <= 1'b1;
            r_err_stage  <= '0;
            r_job_cycles <= '0;
          end
        end
        ST_COUNT, ST_TREE, ST_CODE, ST_ENCODE: begin
          r_job_cycles <= sat_inc(r_job_cycles);
          if (bus.abort) begin
            r_state     <= ST_IDLE;
            r_aborted   <= 1'b1;
            r_busy      <= 1'b0;
            r_tree_over <= 1'b0;
          end else if (w_stage_done) begin
            case (r_state)
              ST_COUNT: begin
                r_state      <= ST_TREE;
                r_tree_start <= 1'b1;
              end
              ST_TREE: begin
                r_state     <= ST_CODE;
                r_tree_over <= 1'b1;
              end
              ST_CODE: begin
                r_state      <= ST_ENCODE;
                r_table_load <= 1'b1;
                r_enc_start  <= 1'b1;
              end
              default: begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
              end
            endcase
          end else if (w_expire) begin
            r_state     <= ST_ERR;
            r_err       <= 1'b1;
            r_err_stage <= r_state;
            r_busy      <= 1'b0;
            r_tree_over <= 1'b0;
          end
        end
        ST_DONE: begin
          r_state     <= ST_IDLE;
          r_aborted   <= bus.abort;
          r_busy      <= 1'b0;
          r_tree_over <= 1'b0;
        end
        ST_ERR: begin
          if (bus.clr_err) begin
            r_state <= ST_IDLE;
            r_err   <= 1'b0;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.cnt_start  = r_cnt_start;
  assign bus.tree_start = r_tree_start;
  assign bus.tree_over  = r_tree_over;
  assign bus.table_load = r_table_load;
  assign bus.enc_start  = r_enc_start;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.aborted    = r_aborted;
  assign bus.err        = r_err;
  assign bus.err_stage  = r_err_stage;
  assign bus.job_cycles = r_job_cycles;

endmodule

// File: tb/tb_huffman_flow_ctrl.sv
// Scoreboard bench: each job is planned as a cycle timeline; a negedge monitor checks events and levels.
module tb_huffman_flow_ctrl;
  localparam int TIMEOUT = 8;
  localparam int TMO_W   = 16;
  localparam int CYC_W   = 20;
  localparam int MAXC    = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;

  huffman_flow_ctrl_if #(.CYC_W(CYC_W)) bus ();

  huffman_flow_ctrl #(.TIMEOUT(TIMEOUT), .TMO_W(TMO_W), .CYC_W(CYC_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event kinds: 1 cnt_start, 2 tree_start, 3 table_load+enc_start, 4 done, 5 aborted, 6 err rise
  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  ev_t evq[$];
  bit  exp_busy [MAXC];
  bit  exp_tov  [MAXC];
  bit  exp_err  [MAXC];
  int  checks = 0;
  int  errors = 0;
  logic prev_err = 1'b0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic void push_ev(input int c, input int k, input int v);
    ev_t e;
    e.cyc  = c;
    e.kind = k;
    e.val  = v;
    evq.push_back(e);
  endfunction

  function automatic logic rb();
    return ($urandom_range(0, 3) == 0);
  endfunction

  task automatic see(input int k, input int v);
    ev_t e;
    if (evq.size() == 0) begin
      check("unexpected_event_kind", k, 0);
    end else begin
      e = evq.pop_front();
      check("event_kind", k, e.kind);
      check("event_cycle", cyc, e.cyc);
      check("event_value", v, e.val);
    end
  endtask

  always @(negedge clk) begin
    if (bus.cnt_start) see(1, int'(bus.err_stage) + int'(bus.job_cycles));
    if (bus.tree_start) see(2, 0);
    if (bus.table_load || bus.enc_start) see(3, int'({bus.table_load, bus.enc_start}));
    if (bus.done) see(4, int'(bus.job_cycles));
    if (bus.aborted) see(5, 0);
    if (bus.err && !prev_err) see(6, int'(bus.err_stage));
    prev_err <= bus.err;
    if (cyc < MAXC)
      check("levels_busy_treeover_err", int'({bus.busy, bus.tree_over, bus.err}),
            int'({exp_busy[cyc], exp_tov[cyc], exp_err[cyc]}));
  end

  function automatic logic dn(input int j, input int i, input int st, input int at);
    return (i == at) ? 1'b1 : ((st == j) ? 1'b0 : rb());
  endfunction

  task automatic all_zero(input string tag);
    check({tag, "_flags"}, int'({bus.cnt_start, bus.tree_start, bus.tree_over, bus.table_load,
                                 bus.enc_start, bus.busy, bus.done, bus.aborted, bus.err}), 0);
    check({tag, "_err_stage"}, int'(bus.err_stage), 0);
    check({tag, "_job_cycles"}, int'(bus.job_cycles), 0);
  endtask

  // Stage delays d* = cycles from a stage's strobe to its done pulse.
  // ab_st: 0 none, 1..4 abort in that wait stage at offset ab_off, 5 abort in DONE.
  task automatic run_job(input int d0, input int d1, input int d2, input int d3,
                         input int ab_st, input int ab_off, input int clr_wait, input bit rst_mid);
    int d[4];
    int stq[$];
    int done_at[5];
    int ab_at, clr_at, rst_at, s, st, idx;
    bit fin;
    d = '{d0, d1, d2, d3};
    done_at = '{default: -1};
    ab_at = -1; clr_at = -1; rst_at = -1; fin = 1'b0;
    s = cyc;
    stq.push_back(0);
    push_ev(s + 1, 1, 0);
    for (int k = 0; k < 4 && !fin; k++) begin
      if (ab_st == k + 1 && ab_off <= d[k] && ab_off <= TIMEOUT - 1) begin
        repeat (ab_off + 1) stq.push_back(k + 1);
        ab_at = stq.size() - 1;
        if (d[k] == ab_off) done_at[k + 1] = ab_at;
        push_ev(s + stq.size(), 5, 0);
        stq.push_back(0);
        if (d[k] == ab_off + 1) done_at[k + 1] = stq.size() - 1;
        fin = 1'b1;
      end else if (rst_mid && k == 3) begin
        repeat (2) stq.push_back(4);
        stq.push_back(0);
        rst_at = stq.size() - 1;
        fin = 1'b1;
      end else if (d[k] <= TIMEOUT - 1) begin
        repeat (d[k] + 1) stq.push_back(k + 1);
        done_at[k + 1] = stq.size() - 1;
        if (k == 0) push_ev(s + stq.size(), 2, 0);
        else if (k == 2) push_ev(s + stq.size(), 3, 3);
        else if (k == 3) push_ev(s + stq.size(), 4, stq.size() - 1);
      end else begin
        repeat (TIMEOUT) stq.push_back(k + 1);
        push_ev(s + stq.size(), 6, k + 1);
        repeat (clr_wait + 1) stq.push_back(6);
        clr_at = stq.size() - 1;
        fin = 1'b1;
      end
    end
    if (!fin) begin
      stq.push_back(5);
      if (ab_st == 5) begin
        ab_at = stq.size() - 1;
        push_ev(s + stq.size(), 5, 0);
      end
    end
    for (int i = 0; i < stq.size(); i++) begin
      idx = s + i;
      if (idx < MAXC) begin
        exp_busy[idx] = (stq[i] >= 1 && stq[i] <= 5);
        exp_tov[idx]  = (stq[i] >= 3 && stq[i] <= 5);
        exp_err[idx]  = (stq[i] == 6);
      end
    end
    for (int i = 0; i < stq.size(); i++) begin
      st = stq[i];
      bus.start     = (i == 0) ? 1'b1 : ((st != 0) ? rb() : 1'b0);
      bus.abort     = (i == ab_at) ? 1'b1 : ((st == 6) ? rb() : 1'b0);
      bus.clr_err   = (i == clr_at) ? 1'b1 : ((st == 6) ? 1'b0 : rb());
      bus.cnt_done  = dn(1, i, st, done_at[1]);
      bus.tree_done = dn(2, i, st, done_at[2]);
      bus.code_over = dn(3, i, st, done_at[3]);
      bus.enc_done  = dn(4, i, st, done_at[4]);
      if (i == rst_at) begin
        #1 rst = 1'b1;
        #1 all_zero("async_reset");
        #4 rst = 1'b0;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      bus.start     = 1'b0;
      bus.abort     = rb();
      bus.clr_err   = rb();
      bus.cnt_done  = rb();
      bus.tree_done = rb();
      bus.code_over = rb();
      bus.enc_done  = rb();
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    int a_st;
    bus.start = 1'b0; bus.abort = 1'b0; bus.clr_err = 1'b0;
    bus.cnt_done = 1'b0; bus.tree_done = 1'b0; bus.code_over = 1'b0; bus.enc_done = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_job(5, 5, 5, 5, 0, 0, 0, 1'b0);   // nominal, job_cycles 24
    idle(2);
    run_job(5, 20, 5, 5, 0, 0, 3, 1'b0);  // TREE timeout
    idle(2);
    run_job(5, 5, 2, 5, 3, 1, 0, 1'b0);   // abort 2nd CODE cycle, late code_over
    idle(2);
    run_job(5, 5, 5, 4, 4, 4, 0, 1'b0);   // abort together with enc_done
    idle(1);
    run_job(5, 5, 5, 7, 0, 0, 0, 1'b0);   // enc_done on the expiry cycle
    run_job(3, 1, 0, 2, 0, 0, 0, 1'b0);   // back-to-back
    run_job(0, 0, 0, 0, 5, 0, 0, 1'b0);   // abort in DONE
    run_job(5, 5, 5, 6, 0, 0, 0, 1'b1);   // async reset mid-ENCODE
    idle(2);
    for (int j = 0; j < 30; j++) begin
      a_st = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 5)) : 0;
      run_job(int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
              int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
              a_st, int'($urandom_range(0, 6)), int'($urandom_range(0, 3)), 1'b0);
      idle(int'($urandom_range(0, 2)));
    end
    idle(3);
    check("events_outstanding", evq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
